// File: rtl/hex_digit_counter.sv
// Rate-divided 4-bit hex digit counter with load, pause, direction
// and chainable Tick/Carry pulses for multi-digit 7-segment displays.
module hex_digit_counter #(
  parameter int CYCLES_1HZ = 50000000,
  parameter int RD_WIDTH   = 28
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Enable,
  input  logic       Load,
  input  logic [3:0] LoadValue,
  input  logic       Up,
  input  logic [1:0] RateSel,
  output logic [3:0] Digit,
  output logic       Tick,
  output logic       Carry
);

  localparam logic [RD_WIDTH-1:0] R0 = '0;
  localparam logic [RD_WIDTH-1:0] R1 =
    RD_WIDTH'(CYCLES_1HZ - 1);
  localparam logic [RD_WIDTH-1:0] R2 =
    RD_WIDTH'(2 * CYCLES_1HZ - 1);
  localparam logic [RD_WIDTH-1:0] R3 =
    RD_WIDTH'(4 * CYCLES_1HZ - 1);

  logic [RD_WIDTH-1:0] rd, rd_nxt, reload;
  logic [1:0]          rs_q, rs_nxt;
  logic [3:0]          digit_nxt;
  logic                tick_nxt, carry_nxt;
  logic                at_zero;

  always_comb begin
    reload = R0;
    unique case (RateSel)
      2'b00: reload = R0;
      2'b01: reload = R1;
      2'b10: reload = R2;
      2'b11: reload = R3;
    endcase
  end

  assign at_zero = (rd == '0);

  // Priority: reset, load, rate change, enabled step/countdown, hold.
  always_comb begin
    rd_nxt    = rd;
    rs_nxt    = rs_q;
    digit_nxt = Digit;
    tick_nxt  = 1'b0;
    carry_nxt = 1'b0;
    if (Reset) begin
      rd_nxt    = reload;
      rs_nxt    = RateSel;
      digit_nxt = 4'h0;
    end else if (Load) begin
      rd_nxt    = reload;
      rs_nxt    = RateSel;
      digit_nxt = LoadValue;
    end else if (RateSel != rs_q) begin
      rd_nxt = reload;
      rs_nxt = RateSel;
    end else if (Enable) begin
      if (!at_zero) begin
        rd_nxt = rd - 1'b1;
      end else begin
        rd_nxt   = reload;
        tick_nxt = 1'b1;
        if (Up) begin
          digit_nxt = Digit + 4'h1;
          carry_nxt = (Digit == 4'hF);
        end else begin
          digit_nxt = Digit - 4'h1;
          carry_nxt = (Digit == 4'h0);
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    rd    <= rd_nxt;
    rs_q  <= rs_nxt;
    Digit <= digit_nxt;
    Tick  <= tick_nxt;
    Carry <= carry_nxt;
  end

endmodule

// File: tb/tb_hex_digit_counter.sv
// Self-checking bench for hex_digit_counter: directed scenarios
// followed by randomized traffic against an elapsed-cycle model.
module tb_hex_digit_counter;

  localparam int C = 4;

  logic       Clock = 1'b0;
  logic       Reset, Enable, Load, Up;
  logic [3:0] LoadValue;
  logic [1:0] RateSel;
  logic [3:0] Digit;
  logic       Tick, Carry;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int         m_digit;
  int         m_el;
  logic [1:0] m_rs;
  logic       m_tick, m_carry;

  hex_digit_counter #(
    .CYCLES_1HZ(C),
    .RD_WIDTH  (8)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Enable   (Enable),
    .Load     (Load),
    .LoadValue(LoadValue),
    .Up       (Up),
    .RateSel  (RateSel),
    .Digit    (Digit),
    .Tick     (Tick),
    .Carry    (Carry)
  );

  always #5 Clock = ~Clock;

  function automatic int period(input logic [1:0] s);
    case (s)
      2'd0:    return 1;
      2'd1:    return C;
      2'd2:    return 2 * C;
      default: return 4 * C;
    endcase
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    m_tick  = 1'b0;
    m_carry = 1'b0;
    if (Reset) begin
      m_digit = 0;
      m_el    = 0;
      m_rs    = RateSel;
    end else if (Load) begin
      m_digit = int'(LoadValue);
      m_el    = 0;
      m_rs    = RateSel;
    end else if (RateSel != m_rs) begin
      m_el = 0;
      m_rs = RateSel;
    end else if (Enable) begin
      if (m_el == period(m_rs) - 1) begin
        m_el   = 0;
        m_tick = 1'b1;
        if (Up) begin
          m_carry = (m_digit == 15);
          m_digit = (m_digit + 1) % 16;
        end else begin
          m_carry = (m_digit == 0);
          m_digit = (m_digit + 15) % 16;
        end
      end else begin
        m_el++;
      end
    end
  endtask

  task automatic cyc();
    @(posedge Clock);
    model_edge();
    #1;
    chk("model_digit", 32'(Digit), 32'(m_digit));
    chk("model_tick", 32'(Tick), 32'(m_tick));
    chk("model_carry", 32'(Carry), 32'(m_carry));
  endtask

  task automatic drive(input logic r, input logic e,
                       input logic l, input logic [3:0] lv,
                       input logic u, input logic [1:0] rs);
    Reset     = r;
    Enable    = e;
    Load      = l;
    LoadValue = lv;
    Up        = u;
    RateSel   = rs;
  endtask

  initial begin
    int ticks;
    int carries;
    m_digit = 0;
    m_el    = 0;
    m_rs    = 2'd0;
    m_tick  = 1'b0;
    m_carry = 1'b0;

    // 1: every-cycle count up with wrap
    drive(1, 1, 0, 4'h0, 1, 2'd0);
    cyc();
    chk("reset_digit", 32'(Digit), 0);
    chk("reset_tick", 32'(Tick), 0);
    chk("reset_carry", 32'(Carry), 0);
    Reset = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      cyc();
      chk("t1_digit", 32'(Digit), 32'(i % 16));
      chk("t1_tick", 32'(Tick), 1);
      chk("t1_carry", 32'(Carry), 32'(i == 16));
    end

    // 2: 1 Hz rate, 16 steps in 64 cycles
    drive(1, 1, 0, 4'h0, 1, 2'd1);
    cyc();
    Reset   = 1'b0;
    ticks   = 0;
    carries = 0;
    for (int i = 1; i <= 64; i++) begin
      cyc();
      chk("t2_tick", 32'(Tick), 32'(i % 4 == 0));
      chk("t2_digit", 32'(Digit), 32'((i / 4) % 16));
      ticks   += int'(Tick);
      carries += int'(Carry);
    end
    chk("t2_ticks", 32'(ticks), 16);
    chk("t2_carries", 32'(carries), 1);

    // 3: load 0 then count down through wrap
    drive(0, 1, 1, 4'h0, 0, 2'd0);
    cyc();
    chk("t3_load", 32'(Digit), 0);
    chk("t3_load_tick", 32'(Tick), 0);
    Load = 1'b0;
    cyc();
    chk("t3_wrap", 32'(Digit), 32'hF);
    chk("t3_wrap_carry", 32'(Carry), 1);
    chk("t3_wrap_tick", 32'(Tick), 1);
    cyc();
    chk("t3_e", 32'(Digit), 32'hE);
    chk("t3_e_carry", 32'(Carry), 0);

    // 4: 0.25 Hz, load A mid-count, next step 16 cycles later
    drive(0, 1, 0, 4'h0, 1, 2'd3);
    cyc();
    chk("t4_ratechg_tick", 32'(Tick), 0);
    cyc();
    cyc();
    drive(0, 1, 1, 4'hA, 1, 2'd3);
    cyc();
    chk("t4_load", 32'(Digit), 32'hA);
    chk("t4_load_tick", 32'(Tick), 0);
    Load = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      cyc();
      chk("t4_digit", 32'(Digit), (i == 16) ? 32'hB : 32'hA);
      chk("t4_tick", 32'(Tick), 32'(i == 16));
    end

    // 5: pause two cycles into a 1 Hz period
    drive(0, 1, 1, 4'h3, 1, 2'd1);
    cyc();
    Load = 1'b0;
    cyc();
    cyc();
    Enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("t5_hold", 32'(Digit), 3);
      chk("t5_hold_tick", 32'(Tick), 0);
    end
    Enable = 1'b1;
    cyc();
    chk("t5_resume1", 32'(Digit), 3);
    cyc();
    chk("t5_resume2", 32'(Digit), 4);
    chk("t5_resume2_tick", 32'(Tick), 1);

    // 6: reset mid-period at 0.5 Hz, then switch 11 -> 00
    drive(0, 1, 1, 4'h7, 1, 2'd2);
    cyc();
    Load = 1'b0;
    cyc();
    cyc();
    cyc();
    Reset = 1'b1;
    cyc();
    chk("t6_rst_digit", 32'(Digit), 0);
    chk("t6_rst_tick", 32'(Tick), 0);
    chk("t6_rst_carry", 32'(Carry), 0);
    Reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      chk("t6_digit", 32'(Digit), 32'(i == 8));
    end
    RateSel = 2'd3;
    for (int i = 0; i < 5; i++) cyc();
    RateSel = 2'd0;
    cyc();
    chk("t6_sw_digit", 32'(Digit), 1);
    chk("t6_sw_tick", 32'(Tick), 0);
    for (int i = 2; i <= 4; i++) begin
      cyc();
      chk("t6_fast", 32'(Digit), 32'(i));
      chk("t6_fast_tick", 32'(Tick), 1);
    end

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      Reset     = ($urandom_range(0, 59) == 0);
      Load      = ($urandom_range(0, 29) == 0);
      LoadValue = 4'($urandom_range(0, 15));
      Enable    = ($urandom_range(0, 9) != 0);
      Up        = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0)
        RateSel = 2'($urandom_range(0, 3));
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hex_digit_counter.md
Name: hex_digit_counter

Overview:
Rate-divided 4-bit hex counter that produces the digit value for the downstream 7-segment decoder. Divides the board clock to a selectable step rate (every cycle, 1 Hz, 0.5 Hz, 0.25 Hz) and steps the digit up or down, with wrap-around, on each divided tick. Supports parallel load, enable/pause, and one-cycle Tick and Carry pulses, so that several instances can be chained for multi-digit displays.

Parameters:
CYCLES_1HZ, 50000000, clock cycles per 1 Hz period; set small (e.g. 4) for simulation
RD_WIDTH, 28, rate-divider width; must hold 4*CYCLES_1HZ-1

Ports:
Clock  input  1  system clock; all state changes on rising edge
Reset  input  1  synchronous, active-high reset
Enable  input  1  1 = count, 0 = pause (divider and digit hold)
Load  input  1  synchronous parallel load of LoadValue
LoadValue  input  4  value loaded into Digit
Up  input  1  1 = increment, 0 = decrement
RateSel  input  2  00 every cycle, 01 1 Hz, 10 0.5 Hz, 11 0.25 Hz
Digit  output  4  current hex digit, registered; drives decoder input
Tick  output  1  registered one-cycle pulse, high in the cycle Digit shows a newly stepped value
Carry  output  1  registered one-cycle pulse, high with Tick when the step wrapped

Behaviour:
- Reload value R(RateSel): 00 -> 0, 01 -> CYCLES_1HZ-1, 10 -> 2*CYCLES_1HZ-1, 11 -> 4*CYCLES_1HZ-1.
- Internal state: down-counter RD[RD_WIDTH-1:0] and registered copy RS_q of RateSel.
- Priority per edge: Reset > Load > RateSel change > Enable step/decrement > hold.
- Reset: Digit=0, Tick=0, Carry=0, RD=R(RateSel), RS_q=RateSel. Takes effect at the edge regardless of other inputs, including mid-period.
- Load (Reset=0): Digit=LoadValue, RD=R(RateSel), RS_q=RateSel, Tick=0, Carry=0. Acts regardless of Enable.
- RateSel != RS_q (no Reset, no Load): RD=R(RateSel), RS_q=RateSel, Digit holds, Tick=0, Carry=0. Applies even when Enable=0.
- Enable=1, RD!=0: RD=RD-1, Tick=0, Carry=0, Digit holds.
- Enable=1, RD==0: step the digit. Up=1 -> Digit=Digit+1 mod 16, Carry=(Digit==F). Up=0 -> Digit=Digit-1 mod 16, Carry=(Digit==0). Also RD=R(RateSel) and Tick=1.
- Enable=0: RD, Digit and RS_q hold; Tick=0, Carry=0. The partial period resumes where it stopped.
- Step period = R+1 enabled cycles. RateSel=00 steps on every enabled edge, with Tick held high continuously.
- Up sampled only at the step edge. Changing it mid-period has no other effect.
- Tick/Carry never high in a Reset, Load or RateSel-change cycle's following output.
- No combinational path from inputs to outputs.

Test Plan:
1. CYCLES_1HZ=4; Reset pulse, RateSel=00, Enable=1, Up=1 -> Digit 0,1,...,F,0 on successive edges; Tick=1 each cycle; Carry=1 only in the cycle Digit returns to 0.
2. RateSel=01, Enable=1, Up=1 from reset -> Digit steps every 4 cycles (0,0,0,0,1,...); Tick high exactly 1 cycle in 4; 16 steps = 64 cycles, Carry once.
3. Load=1, LoadValue=0, then Up=0, RateSel=00 -> Digit=0, then F with Carry=1 and Tick=1, then E with Carry=0.
4. RateSel=11 mid-count, Load=1 LoadValue=A for one cycle -> Digit=A next cycle, Tick=0; next step to B occurs exactly 16 enabled cycles later.
5. RateSel=01, Enable dropped for 10 cycles two cycles into a period -> Digit constant, Tick=0 throughout; after re-enable, step occurs 2 cycles later (remaining count), not 4.
6. RateSel=10 with Digit=7, Reset asserted one cycle mid-period -> Digit=0, Tick=0, Carry=0 next cycle; first step to 1 after 8 enabled cycles. Also switch RateSel 11->00 mid-period -> no step that edge, steps every cycle thereafter.
